// File: rtl/jtbubl_vrom_fetch_if.sv
// Graphics-ROM fetch bus: video-side word request plus the SDRAM slot handshake.
// master = video path / SDRAM controller side, slave = the fetch stage.
interface jtbubl_vrom_fetch_if;
  // Video side: rom_cs/rom_addr are a level request; rom_data is usable only
  // while rom_ok is high. SDRAM side: sdram_req is a level held with a stable
  // sdram_addr until the one-cycle sdram_ack; sdram_rdy later strobes
  // sdram_din for one cycle. At most one request is ever outstanding.
  logic        rom_cs;
  logic [17:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [31:0] sdram_din;

  modport master (
    output rom_cs, rom_addr, sdram_ack, sdram_rdy, sdram_din,
    input  rom_data, rom_ok, sdram_addr, sdram_req
  );

  modport slave (
    input  rom_cs, rom_addr, sdram_ack, sdram_rdy, sdram_din,
    output rom_data, rom_ok, sdram_addr, sdram_req
  );
endinterface

// File: rtl/jtbubl_vrom_fetch.sv
// Bubble Bobble graphics-ROM fetch stage: SDRAM request FSM with a tagged entry store.
// Define JTBUBL_VROM_CACHE_EN for a two-entry LRU tag cache; default keeps one entry.
module jtbubl_vrom_fetch #(
  parameter logic [21:0] BASE_ADDR = 22'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  jtbubl_vrom_fetch_if.slave        vrom,
  output logic [1:0]                state_o
);

`ifdef JTBUBL_VROM_CACHE_EN
  localparam int WAYS = 2;
`else
  localparam int WAYS = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q;
  logic        sdram_req_q;
  logic [21:0] sdram_addr_q;
  logic [17:0] req_addr_q;

  logic [WAYS-1:0] valid_q;
  logic [17:0]     tag_q  [WAYS];
  logic [31:0]     data_q [WAYS];

  logic            rom_ok_q;
  logic            rom_ok_d;
  logic [31:0]     rom_data_q;
  logic [31:0]     rom_data_d;

  logic [WAYS-1:0] way_hit;
  logic            any_hit;
  logic [31:0]     hit_data;
  logic            fill;
  logic            fwd;
  logic [WAYS-1:0] fill_sel;

`ifdef JTBUBL_VROM_CACHE_EN
  // lru_q names the entry the next fill replaces.
  logic lru_q;
  logic lru_d;
`endif

  always_comb begin
    way_hit  = '0;
    hit_data = '0;
    for (int i = 0; i < WAYS; i++) begin
      way_hit[i] = valid_q[i] && (tag_q[i] == vrom.rom_addr);
      if (way_hit[i]) hit_data = data_q[i];
    end
  end

  assign any_hit = |way_hit;
  assign fill    = (state_q == ST_WAIT) && vrom.sdram_rdy;

  // The returning word is forwarded so rom_ok rises the cycle after sdram_rdy
  // rather than waiting a further cycle for the stored entry to be compared.
  assign fwd = fill && vrom.rom_cs && (req_addr_q == vrom.rom_addr);

`ifdef JTBUBL_VROM_CACHE_EN
  assign fill_sel = lru_q ? 2'b10 : 2'b01;

  always_comb begin
    lru_d = lru_q;
    if (fill) lru_d = ~lru_q;
    else if (vrom.rom_cs && any_hit) lru_d = way_hit[0];
  end
`else
  assign fill_sel = 1'b1;
`endif

  always_comb begin
    rom_ok_d   = vrom.rom_cs && (any_hit || fwd);
    rom_data_d = rom_data_q;
    if (fwd) rom_data_d = vrom.sdram_din;
    else if (vrom.rom_cs && any_hit) rom_data_d = hit_data;
  end

  // Request FSM. Address changes never abort a transfer; the next miss is
  // picked up from IDLE once the current word has been stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      req_addr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vrom.rom_cs && !any_hit) begin
            req_addr_q   <= vrom.rom_addr;
            sdram_addr_q <= BASE_ADDR + {4'd0, vrom.rom_addr};
            sdram_req_q  <= 1'b1;
            state_q      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (vrom.sdram_ack) begin
            sdram_req_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (vrom.sdram_rdy) state_q <= ST_IDLE;
        end
        default: begin
          sdram_req_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      rom_ok_q   <= 1'b0;
      rom_data_q <= '0;
      for (int i = 0; i < WAYS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
`ifdef JTBUBL_VROM_CACHE_EN
      lru_q <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        if (fill && fill_sel[i]) begin
          valid_q[i] <= 1'b1;
          tag_q[i]   <= req_addr_q;
          data_q[i]  <= vrom.sdram_din;
        end
      end
      rom_ok_q   <= rom_ok_d;
      rom_data_q <= rom_data_d;
`ifdef JTBUBL_VROM_CACHE_EN
      lru_q <= lru_d;
`endif
    end
  end

  assign vrom.rom_ok     = rom_ok_q;
  assign vrom.rom_data   = rom_data_q;
  assign vrom.sdram_req  = sdram_req_q;
  assign vrom.sdram_addr = sdram_addr_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_jtbubl_vrom_fetch.sv
// Directed bench for jtbubl_vrom_fetch; cache-only expectations follow JTBUBL_VROM_CACHE_EN.
module tb_jtbubl_vrom_fetch;

  localparam logic [21:0] BASE = 22'h100000;
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_REQ  = 2'd1;
  localparam logic [1:0]  S_WAIT = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         checks;
  int         failures;

  jtbubl_vrom_fetch_if vrom ();

  jtbubl_vrom_fetch #(.BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .rst     (rst),
    .vrom    (vrom),
    .state_o (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a missing address and complete its transfer with a minimal handshake.
  task automatic fill(input string tag, input logic [17:0] a, input logic [31:0] d);
    vrom.rom_cs   = 1'b1;
    vrom.rom_addr = a;
    @(negedge clk);
    chk({tag, "_req"}, {31'd0, vrom.sdram_req}, 32'd1);
    chk({tag, "_addr"}, {10'd0, vrom.sdram_addr}, {10'd0, BASE + {4'd0, a}});
    chk({tag, "_ok_low"}, {31'd0, vrom.rom_ok}, 32'd0);
    vrom.sdram_ack = 1'b1;
    @(negedge clk);
    vrom.sdram_ack = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, vrom.sdram_req}, 32'd0);
    vrom.sdram_rdy = 1'b1;
    vrom.sdram_din = d;
    @(negedge clk);
    vrom.sdram_rdy = 1'b0;
    vrom.sdram_din = '0;
    chk({tag, "_ok"}, {31'd0, vrom.rom_ok}, 32'd1);
    chk({tag, "_data"}, vrom.rom_data, d);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    vrom.rom_cs    = 1'b0;
    vrom.rom_addr  = '0;
    vrom.sdram_ack = 1'b0;
    vrom.sdram_rdy = 1'b0;
    vrom.sdram_din = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ok", {31'd0, vrom.rom_ok}, 32'd0);
    chk("rst_data", vrom.rom_data, 32'd0);
    chk("rst_req", {31'd0, vrom.sdram_req}, 32'd0);
    chk("rst_addr", {10'd0, vrom.sdram_addr}, 32'd0);
    chk("rst_state", {30'd0, state}, {30'd0, S_IDLE});
    rst = 1'b0;
    @(negedge clk);

    // basic miss: ack at +2, rdy at +5
    vrom.rom_cs   = 1'b1;
    vrom.rom_addr = 18'h00010;
    @(negedge clk);
    chk("t1_req_rise", {31'd0, vrom.sdram_req}, 32'd1);
    chk("t1_sdram_addr", {10'd0, vrom.sdram_addr}, 32'h00100010);
    chk("t1_ok_low", {31'd0, vrom.rom_ok}, 32'd0);
    @(negedge clk);
    chk("t1_req_hold", {31'd0, vrom.sdram_req}, 32'd1);
    chk("t1_state_req", {30'd0, state}, {30'd0, S_REQ});
    vrom.sdram_ack = 1'b1;
    @(negedge clk);
    vrom.sdram_ack = 1'b0;
    chk("t1_req_drop", {31'd0, vrom.sdram_req}, 32'd0);
    chk("t1_state_wait", {30'd0, state}, {30'd0, S_WAIT});
    @(negedge clk);
    chk("t1_wait_ok_low", {31'd0, vrom.rom_ok}, 32'd0);
    @(negedge clk);
    vrom.sdram_rdy = 1'b1;
    vrom.sdram_din = 32'hDEADBEEF;
    @(negedge clk);
    vrom.sdram_rdy = 1'b0;
    vrom.sdram_din = '0;
    chk("t1_ok", {31'd0, vrom.rom_ok}, 32'd1);
    chk("t1_data", vrom.rom_data, 32'hDEADBEEF);
    chk("t1_state_idle", {30'd0, state}, {30'd0, S_IDLE});
    @(negedge clk);
    chk("t1_ok_hold", {31'd0, vrom.rom_ok}, 32'd1);
    chk("t1_data_hold", vrom.rom_data, 32'hDEADBEEF);
    chk("t1_no_rereq", {31'd0, vrom.sdram_req}, 32'd0);

    // re-present 0x10 after an intervening address
    fill("t2_mid", 18'h00040, 32'h40404040);
    vrom.rom_addr = 18'h00010;
`ifdef JTBUBL_VROM_CACHE_EN
    @(negedge clk);
    chk("t2_hit_ok", {31'd0, vrom.rom_ok}, 32'd1);
    chk("t2_hit_data", vrom.rom_data, 32'hDEADBEEF);
    chk("t2_hit_no_req", {31'd0, vrom.sdram_req}, 32'd0);
`else
    fill("t2_refetch", 18'h00010, 32'hDEADBEEF);
`endif

    // address change during WAIT
    vrom.rom_addr = 18'h00020;
    @(negedge clk);
    chk("t3_req", {31'd0, vrom.sdram_req}, 32'd1);
    vrom.sdram_ack = 1'b1;
    @(negedge clk);
    vrom.sdram_ack = 1'b0;
    vrom.rom_addr  = 18'h00030;
    @(negedge clk);
    chk("t3_no_abort", {30'd0, state}, {30'd0, S_WAIT});
    chk("t3_ok_low_wait", {31'd0, vrom.rom_ok}, 32'd0);
    vrom.sdram_rdy = 1'b1;
    vrom.sdram_din = 32'h20202020;
    @(negedge clk);
    vrom.sdram_rdy = 1'b0;
    vrom.sdram_din = '0;
    chk("t3_ok_low_fill", {31'd0, vrom.rom_ok}, 32'd0);
    chk("t3_idle", {30'd0, state}, {30'd0, S_IDLE});
    chk("t3_req_low_idle", {31'd0, vrom.sdram_req}, 32'd0);
    @(negedge clk);
    chk("t3_req2", {31'd0, vrom.sdram_req}, 32'd1);
    chk("t3_req2_addr", {10'd0, vrom.sdram_addr}, 32'h00100030);
    vrom.sdram_ack = 1'b1;
    @(negedge clk);
    vrom.sdram_ack = 1'b0;
    vrom.sdram_rdy = 1'b1;
    vrom.sdram_din = 32'h30303030;
    @(negedge clk);
    vrom.sdram_rdy = 1'b0;
    vrom.sdram_din = '0;
    chk("t3_ok30", {31'd0, vrom.rom_ok}, 32'd1);
    chk("t3_data30", vrom.rom_data, 32'h30303030);
`ifdef JTBUBL_VROM_CACHE_EN
    vrom.rom_addr = 18'h00020;
    @(negedge clk);
    chk("t3_stored20_ok", {31'd0, vrom.rom_ok}, 32'd1);
    chk("t3_stored20_data", vrom.rom_data, 32'h20202020);
`endif

    // rom_cs low on a stored address
    vrom.rom_cs   = 1'b0;
    vrom.rom_addr = 18'h00030;
    @(negedge clk);
    chk("t4_cs0_ok", {31'd0, vrom.rom_ok}, 32'd0);
    chk("t4_cs0_req", {31'd0, vrom.sdram_req}, 32'd0);
    @(negedge clk);
    chk("t4_cs0_req2", {31'd0, vrom.sdram_req}, 32'd0);
    chk("t4_cs0_state", {30'd0, state}, {30'd0, S_IDLE});
    vrom.rom_cs = 1'b1;
    @(negedge clk);
    chk("t4_cs1_ok", {31'd0, vrom.rom_ok}, 32'd1);
    chk("t4_cs1_data", vrom.rom_data, 32'h30303030);

    // stray ack/rdy in IDLE are ignored
    vrom.sdram_ack = 1'b1;
    vrom.sdram_rdy = 1'b1;
    vrom.sdram_din = 32'hFFFFFFFF;
    @(negedge clk);
    vrom.sdram_ack = 1'b0;
    vrom.sdram_rdy = 1'b0;
    vrom.sdram_din = '0;
    chk("t5_stray_state", {30'd0, state}, {30'd0, S_IDLE});
    chk("t5_stray_data", vrom.rom_data, 32'h30303030);

    // reset in WAIT, then a late rdy
    vrom.rom_addr = 18'h00050;
    @(negedge clk);
    chk("t6_req", {31'd0, vrom.sdram_req}, 32'd1);
    vrom.sdram_ack = 1'b1;
    @(negedge clk);
    vrom.sdram_ack = 1'b0;
    chk("t6_in_wait", {30'd0, state}, {30'd0, S_WAIT});
    rst = 1'b1;
    #1;
    chk("t6_rst_state", {30'd0, state}, {30'd0, S_IDLE});
    chk("t6_rst_req", {31'd0, vrom.sdram_req}, 32'd0);
    chk("t6_rst_addr", {10'd0, vrom.sdram_addr}, 32'd0);
    chk("t6_rst_ok", {31'd0, vrom.rom_ok}, 32'd0);
    chk("t6_rst_data", vrom.rom_data, 32'd0);
    @(negedge clk);
    rst            = 1'b0;
    vrom.rom_cs    = 1'b0;
    vrom.sdram_rdy = 1'b1;
    vrom.sdram_din = 32'h12345678;
    @(negedge clk);
    vrom.sdram_rdy = 1'b0;
    vrom.sdram_din = '0;
    chk("t6_late_rdy_state", {30'd0, state}, {30'd0, S_IDLE});
    chk("t6_late_rdy_data", vrom.rom_data, 32'd0);
    chk("t6_late_rdy_req", {31'd0, vrom.sdram_req}, 32'd0);
    fill("t6_refetch", 18'h00050, 32'h55555555);

`ifdef JTBUBL_VROM_CACHE_EN
    // LRU replacement from a clean store
    rst         = 1'b1;
    vrom.rom_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill("t7_a", 18'h00001, 32'hAAAA0001);
    fill("t7_b", 18'h00002, 32'hBBBB0002);
    vrom.rom_addr = 18'h00001;
    @(negedge clk);
    chk("t7_a_hit", {31'd0, vrom.rom_ok}, 32'd1);
    chk("t7_a_hit_req", {31'd0, vrom.sdram_req}, 32'd0);
    fill("t7_c", 18'h00003, 32'hCCCC0003);
    vrom.rom_addr = 18'h00001;
    @(negedge clk);
    chk("t7_a_still_ok", {31'd0, vrom.rom_ok}, 32'd1);
    chk("t7_a_still_data", vrom.rom_data, 32'hAAAA0001);
    vrom.rom_addr = 18'h00002;
    @(negedge clk);
    chk("t7_b_evicted_ok", {31'd0, vrom.rom_ok}, 32'd0);
    chk("t7_b_evicted_req", {31'd0, vrom.sdram_req}, 32'd1);
    vrom.sdram_ack = 1'b1;
    @(negedge clk);
    vrom.sdram_ack = 1'b0;
    vrom.sdram_rdy = 1'b1;
    @(negedge clk);
    vrom.sdram_rdy = 1'b0;
`endif

    vrom.rom_cs = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
